// File: rtl/debug_commit_tracker_if.sv
// Writeback-to-debug bundle: retiring instruction fields in, commit records and status out.
// The master drives writeback; the slave is the commit tracker.
interface debug_commit_tracker_if;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [31:0] wb_inst;
    logic        wb_regWen;
    logic [4:0]  wb_regWaddr;
    logic [31:0] wb_regWdata;
    logic        wb_memEn;
    logic [31:0] wb_memAddr;

    logic        debug_valid;
    logic        debug_halt;
    logic        debug_deviceAccess;
    logic [31:0] debug_deviceAddr;
    logic [31:0] debug_pc;
    logic        debug_regWen;
    logic [4:0]  debug_regWaddr;
    logic [31:0] debug_regWdata;
    logic [31:0] halt_code;
    logic        halt_timeout;
    logic [63:0] instret;
    logic [63:0] cycles;

    modport master (
        output wb_valid, wb_pc, wb_inst, wb_regWen, wb_regWaddr, wb_regWdata, wb_memEn, wb_memAddr,
        input  debug_valid, debug_halt, debug_deviceAccess, debug_deviceAddr, debug_pc,
               debug_regWen, debug_regWaddr, debug_regWdata, halt_code, halt_timeout, instret, cycles
    );

    modport slave (
        input  wb_valid, wb_pc, wb_inst, wb_regWen, wb_regWaddr, wb_regWdata, wb_memEn, wb_memAddr,
        output debug_valid, debug_halt, debug_deviceAccess, debug_deviceAddr, debug_pc,
               debug_regWen, debug_regWaddr, debug_regWdata, halt_code, halt_timeout, instret, cycles
    );
endinterface

// File: rtl/debug_commit_tracker.sv
// Registers each retired instruction into a one-cycle debug record and halts on ebreak
// or when the no-commit watchdog expires. Also tracks retire/cycle counts and an a0 shadow.
module debug_commit_tracker #(
    parameter logic [31:0] WDOG_CYCLES = 32'd100000,
    parameter logic [31:0] MEM0_BASE   = 32'h8000_0000,
    parameter int          MEM0_LOG2   = 27,
    parameter logic [31:0] MEM1_BASE   = 32'h0F00_0000,
    parameter int          MEM1_LOG2   = 13
) (
    input  logic                         clock,
    input  logic                         reset,
    debug_commit_tracker_if.slave        bus
);
    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    typedef enum logic [0:0] {ST_RUN, ST_HALTED} state_t;

    state_t      state_q, state_d;
    logic [31:0] wdog_q, wdog_d;
    logic [31:0] a0_q, a0_d;
    logic [31:0] last_pc_q, last_pc_d;
    logic        valid_q, valid_d;
    logic        halt_q, halt_d;
    logic        dev_q, dev_d;
    logic [31:0] dev_addr_q, dev_addr_d;
    logic [31:0] pc_q, pc_d;
    logic        reg_wen_q, reg_wen_d;
    logic [4:0]  reg_waddr_q, reg_waddr_d;
    logic [31:0] reg_wdata_q, reg_wdata_d;
    logic [31:0] halt_code_q, halt_code_d;
    logic        timeout_q, timeout_d;
    logic [63:0] instret_q, instret_d;
    logic [63:0] cycles_q, cycles_d;

    logic in_mem0, in_mem1, dev_hit, is_ebreak, wdog_expire;

    assign in_mem0     = (bus.wb_memAddr[31:MEM0_LOG2] == MEM0_BASE[31:MEM0_LOG2]);
    assign in_mem1     = (bus.wb_memAddr[31:MEM1_LOG2] == MEM1_BASE[31:MEM1_LOG2]);
    assign dev_hit     = bus.wb_memEn && !in_mem0 && !in_mem1;
    assign is_ebreak   = (bus.wb_inst == EBREAK_INST);
    // Expires in the idle cycle that brings the count up to WDOG_CYCLES.
    assign wdog_expire = (WDOG_CYCLES != 32'd0) && (wdog_q == WDOG_CYCLES - 32'd1);

    always_comb begin
        state_d     = state_q;
        wdog_d      = wdog_q;
        a0_d        = a0_q;
        last_pc_d   = last_pc_q;
        valid_d     = 1'b0;
        halt_d      = halt_q;
        dev_d       = dev_q;
        dev_addr_d  = dev_addr_q;
        pc_d        = pc_q;
        reg_wen_d   = reg_wen_q;
        reg_waddr_d = reg_waddr_q;
        reg_wdata_d = reg_wdata_q;
        halt_code_d = halt_code_q;
        timeout_d   = timeout_q;
        instret_d   = instret_q;
        cycles_d    = cycles_q;

        if (state_q == ST_RUN) begin
            cycles_d = cycles_q + 64'd1;
            if (bus.wb_valid) begin
                valid_d     = 1'b1;
                halt_d      = is_ebreak;
                dev_d       = dev_hit;
                dev_addr_d  = dev_hit ? bus.wb_memAddr : 32'd0;
                pc_d        = bus.wb_pc;
                reg_wen_d   = bus.wb_regWen && (bus.wb_regWaddr != 5'd0);
                reg_waddr_d = bus.wb_regWaddr;
                reg_wdata_d = bus.wb_regWdata;
                instret_d   = instret_q + 64'd1;
                wdog_d      = 32'd0;
                last_pc_d   = bus.wb_pc;
                if (bus.wb_regWen && bus.wb_regWaddr == 5'd10) begin
                    a0_d = bus.wb_regWdata;
                end
                if (is_ebreak) begin
                    halt_code_d = a0_q;
                    state_d     = ST_HALTED;
                end
            end else if (wdog_expire) begin
                // Synthetic halt record reporting the last committed pc.
                valid_d     = 1'b1;
                halt_d      = 1'b1;
                dev_d       = 1'b0;
                dev_addr_d  = 32'd0;
                pc_d        = last_pc_q;
                reg_wen_d   = 1'b0;
                reg_waddr_d = 5'd0;
                reg_wdata_d = 32'd0;
                halt_code_d = a0_q;
                timeout_d   = 1'b1;
                state_d     = ST_HALTED;
            end else if (WDOG_CYCLES != 32'd0) begin
                wdog_d = wdog_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            wdog_q      <= 32'd0;
            a0_q        <= 32'd0;
            last_pc_q   <= 32'd0;
            valid_q     <= 1'b0;
            halt_q      <= 1'b0;
            dev_q       <= 1'b0;
            dev_addr_q  <= 32'd0;
            pc_q        <= 32'd0;
            reg_wen_q   <= 1'b0;
            reg_waddr_q <= 5'd0;
            reg_wdata_q <= 32'd0;
            halt_code_q <= 32'd0;
            timeout_q   <= 1'b0;
            instret_q   <= 64'd0;
            cycles_q    <= 64'd0;
        end else begin
            state_q     <= state_d;
            wdog_q      <= wdog_d;
            a0_q        <= a0_d;
            last_pc_q   <= last_pc_d;
            valid_q     <= valid_d;
            halt_q      <= halt_d;
            dev_q       <= dev_d;
            dev_addr_q  <= dev_addr_d;
            pc_q        <= pc_d;
            reg_wen_q   <= reg_wen_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
            halt_code_q <= halt_code_d;
            timeout_q   <= timeout_d;
            instret_q   <= instret_d;
            cycles_q    <= cycles_d;
        end
    end

    assign bus.debug_valid        = valid_q;
    assign bus.debug_halt         = halt_q;
    assign bus.debug_deviceAccess = dev_q;
    assign bus.debug_deviceAddr   = dev_addr_q;
    assign bus.debug_pc           = pc_q;
    assign bus.debug_regWen       = reg_wen_q;
    assign bus.debug_regWaddr     = reg_waddr_q;
    assign bus.debug_regWdata     = reg_wdata_q;
    assign bus.halt_code          = halt_code_q;
    assign bus.halt_timeout       = timeout_q;
    assign bus.instret            = instret_q;
    assign bus.cycles             = cycles_q;
endmodule

// File: tb/tb_debug_commit_tracker.sv
// Bench for debug_commit_tracker: directed scenarios plus randomized traffic checked
// against a transaction-level reference model of the commit/halt rules.
module tb_debug_commit_tracker;
    localparam logic [31:0] WDOG   = 32'd8;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [63:0] M0_BASE = 64'h8000_0000;
    localparam logic [63:0] M0_SIZE = 64'd1 << 27;
    localparam logic [63:0] M1_BASE = 64'h0F00_0000;
    localparam logic [63:0] M1_SIZE = 64'd1 << 13;

    logic clock;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    debug_commit_tracker_if dif ();

    debug_commit_tracker #(
        .WDOG_CYCLES (WDOG),
        .MEM0_BASE   (32'h8000_0000),
        .MEM0_LOG2   (27),
        .MEM1_BASE   (32'h0F00_0000),
        .MEM1_LOG2   (13)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (dif.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached, required finish before it");
        $fatal(1, "timeout");
    end

    // Reference model state
    logic        m_halted;
    int unsigned m_idle;
    logic [31:0] m_a0, m_last_pc;
    logic [63:0] m_instret, m_cycles;
    logic        e_valid, e_halt, e_dev, e_regwen, e_timeout;
    logic [31:0] e_devaddr, e_pc, e_wdata, e_code;
    logic [4:0]  e_waddr;

    logic [265:0] obs;
    assign obs = {dif.debug_valid, dif.debug_halt, dif.debug_deviceAccess, dif.debug_deviceAddr,
                  dif.debug_pc, dif.debug_regWen, dif.debug_regWaddr, dif.debug_regWdata,
                  dif.halt_code, dif.halt_timeout, dif.instret, dif.cycles};

    function automatic logic [265:0] model_vec();
        return {e_valid, e_halt, e_dev, e_devaddr, e_pc, e_regwen, e_waddr, e_wdata,
                e_code, e_timeout, m_instret, m_cycles};
    endfunction

    function automatic logic in_window(input logic [31:0] a);
        logic [63:0] x;
        x = {32'd0, a};
        return (x >= M0_BASE && x < M0_BASE + M0_SIZE) || (x >= M1_BASE && x < M1_BASE + M1_SIZE);
    endfunction

    task automatic model_reset();
        m_halted = 1'b0; m_idle = 0; m_a0 = '0; m_last_pc = '0; m_instret = '0; m_cycles = '0;
        e_valid = 0; e_halt = 0; e_dev = 0; e_regwen = 0; e_timeout = 0;
        e_devaddr = '0; e_pc = '0; e_wdata = '0; e_code = '0; e_waddr = '0;
    endtask

    // One clock edge of the specified behaviour, given the inputs seen at that edge.
    task automatic model_edge(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                              input logic rw, input logic [4:0] wa, input logic [31:0] wd,
                              input logic me, input logic [31:0] ma);
        e_valid = 1'b0;
        if (m_halted) return;
        m_cycles = m_cycles + 1;
        if (v) begin
            e_valid = 1; e_halt = (inst == EBREAK); e_pc = pc;
            e_regwen = rw && (wa != 0); e_waddr = wa; e_wdata = wd;
            e_dev = me && !in_window(ma); e_devaddr = e_dev ? ma : 32'd0;
            m_instret = m_instret + 1; m_idle = 0; m_last_pc = pc;
            if (e_halt) begin e_code = m_a0; m_halted = 1; end
            if (rw && wa == 5'd10) m_a0 = wd;
        end else begin
            m_idle++;
            if (WDOG != 0 && m_idle == WDOG) begin
                e_valid = 1; e_halt = 1; e_pc = m_last_pc; e_regwen = 0; e_waddr = 0; e_wdata = 0;
                e_dev = 0; e_devaddr = 0; e_timeout = 1; e_code = m_a0; m_halted = 1;
            end
        end
    endtask

    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic rw, input logic [4:0] wa, input logic [31:0] wd,
                        input logic me, input logic [31:0] ma);
        dif.wb_valid = v; dif.wb_pc = pc; dif.wb_inst = inst; dif.wb_regWen = rw;
        dif.wb_regWaddr = wa; dif.wb_regWdata = wd; dif.wb_memEn = me; dif.wb_memAddr = ma;
        @(posedge clock);
        model_edge(v, pc, inst, rw, wa, wd, me, ma);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'd0, 32'h0000_0013, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic do_reset();
        dif.wb_valid = 0; dif.wb_pc = 0; dif.wb_inst = 0; dif.wb_regWen = 0;
        dif.wb_regWaddr = 0; dif.wb_regWdata = 0; dif.wb_memEn = 0; dif.wb_memAddr = 0;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, required all zero", obs);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs [3];
        pcs[0] = 32'h8000_0000; pcs[1] = 32'h8000_0004; pcs[2] = 32'h8000_0008;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, pcs[i], 32'h0110_0293, 1'b1, 5'd5, 32'h11, 1'b0, 32'd0);
            n_tests++;
            if ({dif.debug_valid, dif.debug_pc, dif.debug_regWen, dif.debug_regWaddr, dif.debug_regWdata}
                !== {1'b1, pcs[i], 1'b1, 5'd5, 32'h11}) begin
                n_fail++;
                $display("FAIL b2b_record%0d: valid=%b pc=%h wen=%b waddr=%0d wdata=%h, required valid=1 pc=%h x5<=11",
                         i, dif.debug_valid, dif.debug_pc, dif.debug_regWen, dif.debug_regWaddr,
                         dif.debug_regWdata, pcs[i]);
            end
        end
        n_tests++;
        if (dif.instret !== 64'd3) begin
            n_fail++; $display("FAIL b2b_instret: got %0d, required 3", dif.instret);
        end
        idle();
        n_tests++;
        if ({dif.debug_valid, dif.debug_pc, dif.cycles} !== {1'b0, 32'h8000_0008, 64'd4}) begin
            n_fail++;
            $display("FAIL b2b_hold: valid=%b pc=%h cycles=%0d, required valid=0 pc=80000008 cycles=4",
                     dif.debug_valid, dif.debug_pc, dif.cycles);
        end
    endtask

    task automatic test_x0_write();
        do_reset();
        step(1'b1, 32'h8000_0010, 32'h0000_0033, 1'b1, 5'd0, 32'hDEAD, 1'b0, 32'd0);
        n_tests++;
        if ({dif.debug_valid, dif.debug_regWen, dif.debug_regWaddr} !== {1'b1, 1'b0, 5'd0}) begin
            n_fail++;
            $display("FAIL x0_write: valid=%b wen=%b waddr=%0d, required valid=1 wen=0 waddr=0",
                     dif.debug_valid, dif.debug_regWen, dif.debug_regWaddr);
        end
    endtask

    task automatic test_device_access();
        logic [31:0] addrs [3];
        logic        devs  [3];
        addrs[0] = 32'h1000_0000; devs[0] = 1'b1;
        addrs[1] = 32'h8000_0010; devs[1] = 1'b0;
        addrs[2] = 32'h0F00_1000; devs[2] = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h8000_0020 + 32'(i * 4), 32'h0050_2023, 1'b0, 5'd0, 32'd0, 1'b1, addrs[i]);
            n_tests++;
            if ({dif.debug_deviceAccess, dif.debug_deviceAddr} !== {devs[i], devs[i] ? addrs[i] : 32'd0}) begin
                n_fail++;
                $display("FAIL device_access%0d: dev=%b addr=%h, required dev=%b for store to %h",
                         i, dif.debug_deviceAccess, dif.debug_deviceAddr, devs[i], addrs[i]);
            end
        end
    endtask

    task automatic test_ebreak_halt();
        logic [63:0] cyc_at_halt;
        do_reset();
        step(1'b1, 32'h8000_00FC, 32'h02A0_0513, 1'b1, 5'd10, 32'h2A, 1'b0, 32'd0);
        step(1'b1, 32'h8000_0100, EBREAK, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
        n_tests++;
        if ({dif.debug_valid, dif.debug_halt, dif.debug_pc, dif.halt_code, dif.halt_timeout}
            !== {1'b1, 1'b1, 32'h8000_0100, 32'h2A, 1'b0}) begin
            n_fail++;
            $display("FAIL ebreak_record: valid=%b halt=%b pc=%h code=%h timeout=%b, required 1 1 80000100 0000002a 0",
                     dif.debug_valid, dif.debug_halt, dif.debug_pc, dif.halt_code, dif.halt_timeout);
        end
        cyc_at_halt = dif.cycles;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h8000_0104 + 32'(i * 4), 32'h0000_0013, 1'b1, 5'd10, 32'h55, 1'b0, 32'd0);
            n_tests++;
            if ({dif.debug_valid, dif.instret, dif.cycles, dif.halt_code} !== {1'b0, 64'd2, cyc_at_halt, 32'h2A}) begin
                n_fail++;
                $display("FAIL halted_ignore%0d: valid=%b instret=%0d cycles=%0d code=%h, required valid=0 instret=2 cycles=%0d code=2a",
                         i, dif.debug_valid, dif.instret, dif.cycles, dif.halt_code, cyc_at_halt);
            end
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        step(1'b1, 32'h8000_0040, 32'h0000_0013, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
        for (int i = 1; i < 8; i++) begin
            idle();
            n_tests++;
            if (dif.debug_valid !== 1'b0) begin
                n_fail++; $display("FAIL wdog_early%0d: valid=%b, required 0", i, dif.debug_valid);
            end
        end
        idle();
        n_tests++;
        if ({dif.debug_valid, dif.debug_halt, dif.debug_pc, dif.debug_regWen, dif.debug_deviceAccess, dif.halt_timeout}
            !== {1'b1, 1'b1, 32'h8000_0040, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL wdog_record: valid=%b halt=%b pc=%h wen=%b dev=%b timeout=%b, required 1 1 80000040 0 0 1",
                     dif.debug_valid, dif.debug_halt, dif.debug_pc, dif.debug_regWen,
                     dif.debug_deviceAccess, dif.halt_timeout);
        end
        idle();
        n_tests++;
        if ({dif.debug_valid, dif.halt_timeout} !== {1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL wdog_after: valid=%b timeout=%b, required valid=0 timeout=1", dif.debug_valid, dif.halt_timeout);
        end
    endtask

    task automatic test_watchdog_cancel();
        do_reset();
        step(1'b1, 32'h8000_0040, 32'h0000_0013, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
        repeat (7) idle();
        step(1'b1, 32'h8000_0044, 32'h0000_0013, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
        n_tests++;
        if ({dif.debug_valid, dif.debug_halt, dif.debug_pc, dif.halt_timeout} !== {1'b1, 1'b0, 32'h8000_0044, 1'b0}) begin
            n_fail++;
            $display("FAIL wdog_cancel: valid=%b halt=%b pc=%h timeout=%b, required 1 0 80000044 0",
                     dif.debug_valid, dif.debug_halt, dif.debug_pc, dif.halt_timeout);
        end
        repeat (7) idle();
        n_tests++;
        if (dif.debug_valid !== 1'b0) begin
            n_fail++; $display("FAIL wdog_restart_early: valid=%b, required 0", dif.debug_valid);
        end
        idle();
        n_tests++;
        if ({dif.debug_valid, dif.debug_pc, dif.halt_timeout} !== {1'b1, 32'h8000_0044, 1'b1}) begin
            n_fail++;
            $display("FAIL wdog_restart: valid=%b pc=%h timeout=%b, required 1 80000044 1",
                     dif.debug_valid, dif.debug_pc, dif.halt_timeout);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1'b1, 32'h8000_0200, 32'h0000_0013, 1'b1, 5'd10, 32'h77, 1'b1, 32'h1000_0004);
        dif.wb_pc = 32'h8000_0204;
        #2;
        reset = 1'b0;
        @(posedge clock);
        #1;
        n_tests++;
        if (obs !== '0) begin
            n_fail++; $display("FAIL reset_mid_clear: got %h, required all zero", obs);
        end
        reset = 1'b1;
        model_reset();
        idle();
        n_tests++;
        if ({dif.debug_valid, dif.debug_pc, dif.instret} !== {1'b0, 32'd0, 64'd0}) begin
            n_fail++;
            $display("FAIL reset_mid_drop: valid=%b pc=%h instret=%0d, required 0 0 0",
                     dif.debug_valid, dif.debug_pc, dif.instret);
        end
    endtask

    task automatic test_random();
        int          idle_left = 0;
        logic        v, rw, me;
        logic [31:0] pc, inst, wd, ma;
        logic [4:0]  wa;
        logic [31:0] edge_addrs [4];
        edge_addrs[0] = 32'h7FFF_FFFC; edge_addrs[1] = 32'h8800_0000;
        edge_addrs[2] = 32'h0F00_2000; edge_addrs[3] = 32'h0EFF_FFFF;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if (m_halted && $urandom_range(0, 9) == 0) do_reset();
            if (idle_left > 0) begin
                idle_left--; v = 1'b0;
            end else if ($urandom_range(0, 79) == 0) begin
                idle_left = $urandom_range(5, 12); v = 1'b0;
            end else begin
                v = ($urandom_range(0, 9) < 7);
            end
            pc = {$urandom} & 32'hFFFF_FFFC;
            rw = $urandom_range(0, 1) == 1;
            wa = ($urandom_range(0, 3) == 0) ? 5'd10 : 5'($urandom_range(0, 31));
            wd = $urandom;
            me = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 3))
                0:       ma = 32'h8000_0000 | ($urandom & 32'h07FF_FFFF);
                1:       ma = 32'h0F00_0000 | ($urandom & 32'h0000_1FFF);
                2:       ma = $urandom;
                default: ma = edge_addrs[$urandom_range(0, 3)];
            endcase
            if ($urandom_range(0, 39) == 0) begin
                inst = EBREAK; rw = 1'b0;
            end else begin
                inst = $urandom;
            end
            step(v, pc, inst, rw, wa, wd, me, ma);
            n_tests++;
            if (obs !== model_vec()) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %h, required %h", i, obs, model_vec());
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        model_reset();
        test_reset();
        test_back_to_back();
        test_x0_write();
        test_device_access();
        test_ebreak_halt();
        test_watchdog();
        test_watchdog_cancel();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
